// File: rtl/hv_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hv_timing_gen                                             |
// | Purpose  : Parametrised raster timing generator. Produces H/V        |
// |            counters, blanking, sync, DE, SOF/EOL strobes and a       |
// |            blanked, registered RGB stream. Advances on CE_PIX only.  |
// |            Runtime H/V sync offsets are taken at frame boundaries.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module hv_timing_gen #(
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 22,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 42,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 12,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 20,
  parameter int HW       = 9,
  parameter int VW       = 9,
  parameter int CW       = 12,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          MCLK,
  input  logic          RESET_N,
  input  logic          CE_PIX,
  input  logic [3:0]    H_ADJ,
  input  logic [3:0]    V_ADJ,
  input  logic [CW-1:0] iRGB,
  output logic [HW-1:0] HPOS,
  output logic [VW-1:0] VPOS,
  output logic          HBLK,
  output logic          VBLK,
  output logic          HSYN,
  output logic          VSYN,
  output logic          DE,
  output logic [CW-1:0] oRGB,
  output logic          SOF,
  output logic          EOL
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);

  // Sync window bounds, one bit wider than the counters so that a
  // negative offset cannot wrap before the clamp sees it.
  localparam logic signed [HW:0] HS_NOM = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic signed [HW:0] HS_MIN = (HW+1)'(H_ACTIVE);
  localparam logic signed [HW:0] HS_MAX = (HW+1)'(H_TOTAL - H_SYNC);
  localparam logic        [HW:0] HS_LEN = (HW+1)'(H_SYNC);
  localparam logic signed [VW:0] VS_NOM = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic signed [VW:0] VS_MIN = (VW+1)'(V_ACTIVE);
  localparam logic signed [VW:0] VS_MAX = (VW+1)'(V_TOTAL - V_SYNC);
  localparam logic        [VW:0] VS_LEN = (VW+1)'(V_SYNC);

  // Level driven while a sync window is open is inverted for active-low
  localparam logic SYNC_INV = ~SYNC_POL;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [3:0]    ha_q, ha_d;
  logic [3:0]    va_q, va_d;
  logic          hblk_q, hblk_d;
  logic          vblk_q, vblk_d;
  logic          hsyn_q, hsyn_d;
  logic          vsyn_q, vsyn_d;
  logic          de_q, de_d;
  logic [CW-1:0] rgb_q, rgb_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;

  logic signed [HW:0] w_hs_raw, w_hs_start;
  logic signed [VW:0] w_vs_raw, w_vs_start;
  logic        [HW:0] w_hcnt_x;
  logic        [VW:0] w_vcnt_x;
  logic               w_hs_act, w_vs_act;

  // Clamped sync start positions and in-window flags for the current count
  always_comb begin
    w_hs_raw = HS_NOM + $signed({{(HW-3){ha_q[3]}}, ha_q});
    w_vs_raw = VS_NOM + $signed({{(VW-3){va_q[3]}}, va_q});

    if (w_hs_raw < HS_MIN)      w_hs_start = HS_MIN;
    else if (w_hs_raw > HS_MAX) w_hs_start = HS_MAX;
    else                        w_hs_start = w_hs_raw;

    if (w_vs_raw < VS_MIN)      w_vs_start = VS_MIN;
    else if (w_vs_raw > VS_MAX) w_vs_start = VS_MAX;
    else                        w_vs_start = w_vs_raw;

    // Clamped starts are never negative, so unsigned compares are safe
    w_hcnt_x = {1'b0, hcnt_q};
    w_vcnt_x = {1'b0, vcnt_q};
    w_hs_act = (w_hcnt_x >= $unsigned(w_hs_start)) &&
               (w_hcnt_x <  ($unsigned(w_hs_start) + HS_LEN));
    w_vs_act = (w_vcnt_x >= $unsigned(w_vs_start)) &&
               (w_vcnt_x <  ($unsigned(w_vs_start) + VS_LEN));
  end

  // Counter advance, line/frame wrap and frame-boundary offset sampling
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    ha_d   = ha_q;
    va_d   = va_q;
    if (CE_PIX) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
          ha_d   = H_ADJ;
          va_d   = V_ADJ;
        end else begin
          vcnt_d = vcnt_q + VW'(1);
        end
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  // Output stage built from the pre-increment count; strobes self-clear
  always_comb begin
    hblk_d = hblk_q;
    vblk_d = vblk_q;
    hsyn_d = hsyn_q;
    vsyn_d = vsyn_q;
    de_d   = de_q;
    rgb_d  = rgb_q;
    sof_d  = 1'b0;
    eol_d  = 1'b0;
    if (CE_PIX) begin
      hblk_d = (hcnt_q >= H_ACT_C);
      vblk_d = (vcnt_q >= V_ACT_C);
      de_d   = ~(hblk_d | vblk_d);
      hsyn_d = w_hs_act ^ SYNC_INV;
      // VSYN only moves at the start of a line so it never toggles mid-line
      if (hcnt_q == '0) vsyn_d = w_vs_act ^ SYNC_INV;
      rgb_d  = de_d ? iRGB : '0;
      sof_d  = (hcnt_q == '0) && (vcnt_q == '0);
      eol_d  = (hcnt_q == H_LAST);
    end
  end

  // State register with synchronous active-low reset overriding CE_PIX
  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      ha_q   <= '0;
      va_q   <= '0;
      hblk_q <= 1'b1;
      vblk_q <= 1'b1;
      hsyn_q <= SYNC_INV;
      vsyn_q <= SYNC_INV;
      de_q   <= 1'b0;
      rgb_q  <= '0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      ha_q   <= ha_d;
      va_q   <= va_d;
      hblk_q <= hblk_d;
      vblk_q <= vblk_d;
      hsyn_q <= hsyn_d;
      vsyn_q <= vsyn_d;
      de_q   <= de_d;
      rgb_q  <= rgb_d;
      sof_q  <= sof_d;
      eol_q  <= eol_d;
    end
  end

  assign HPOS = hcnt_q;
  assign VPOS = vcnt_q;
  assign HBLK = hblk_q;
  assign VBLK = vblk_q;
  assign HSYN = hsyn_q;
  assign VSYN = vsyn_q;
  assign DE   = de_q;
  assign oRGB = rgb_q;
  assign SOF  = sof_q;
  assign EOL  = eol_q;

endmodule
`default_nettype wire
